freq_gate_counter: RTL and testbench
====================================

// Module: freq_gate_counter
// PURPOSE
//   Reciprocal frequency-measurement core, clocked by the 200 MHz PLL output (outclk_0).
//   Synchronises an asynchronous input signal and counts its rising edges over a gate of
//   at least GATE_CYCLES reference cycles. The gate is aligned to signal edges on both ends.
//   Returns the pair (edge_count, ref_count) to the Nios/display side over a valid/ready
//   handshake. Measurement runs only while the PLL reports lock.
// PARAMETERS
//   CNT_W          32           width of edge_count / ref_count
//   GATE_CYCLES    200000000    minimum gate length in refclk cycles (1 s at 200 MHz)
//   TIMEOUT_CYCLES 400000000    max refclk cycles allowed between consecutive counted edges
//   SYNC_STAGES    2            synchroniser depth for sig_in (>=2)
//   Legal: GATE_CYCLES + TIMEOUT_CYCLES < 2**CNT_W; GATE_CYCLES >= 1; TIMEOUT_CYCLES >= 1
// PORTS
//   refclk        in   1      measurement clock (PLL outclk_0)
//   rst           in   1      asynchronous, active-high reset
//   pll_locked    in   1      PLL lock indicator (async; synchronised internally, 2 flops)
//   enable        in   1      measurement enable from control register
//   sig_in        in   1      asynchronous signal under measurement
//   result_valid  out  1      result held and valid
//   result_ready  in   1      consumer accepts the result when high together with result_valid
//   edge_count    out  CNT_W  number of whole sig_in periods in the gate
//   ref_count     out  CNT_W  refclk cycles spanned by those periods
//   timeout       out  1      result is a timeout (counts = 0)
//   busy          out  1      high in ARM, MEASURE and CLOSE
// BEHAVIOUR
//   Reset: all outputs 0; FSM in IDLE; synchroniser flops 0. Async assert; release takes effect on refclk.
//   rise: one-cycle pulse = sync & ~sync_d. Pin edge to pulse latency = SYNC_STAGES+1 cycles.
//   run = locked_sync & enable.
//   FSM:
//   IDLE   : run -> ARM (one-cycle turnaround).
//   ARM    : wait for rise. On rise: ref_cnt<=0, edge_cnt<=0, tmo_cnt<=0, -> MEASURE.
//            If TIMEOUT_CYCLES cycles pass with no rise -> DONE with timeout=1.
//   MEASURE: ref_cnt++ every cycle. On rise: edge_cnt++, tmo_cnt<=0.
//            When ref_cnt reaches GATE_CYCLES-1 -> CLOSE.
//   CLOSE  : ref_cnt++. On the first rise: edge_cnt++ -> DONE.
//   DONE   : on entry, latch edge_count/ref_count/timeout and set result_valid.
//            Hold all of them stable until result_valid & result_ready, then -> IDLE.
//   Definitions:
//     ref_count = cycle index of the terminating rise minus cycle index of the starting rise.
//     The gate ends at the first rise at or after GATE_CYCLES cycles from the start.
//   Timeout: tmo_cnt counts cycles since the last rise in MEASURE and CLOSE (and in ARM).
//     Reaching TIMEOUT_CYCLES -> DONE with timeout=1, edge_count=0, ref_count=0.
//   Abort: run low in ARM, MEASURE or CLOSE -> IDLE next cycle. No result; busy falls.
//     Abort takes priority over a simultaneous rise, gate end or timeout.
//     In DONE, run low does not drop a held result.
//   Backpressure: no new measurement starts while result_valid=1. sig_in edges are ignored then.
//   Counters never wrap: the legal-parameter rule plus the timeout bound them.
//   No combinational path from inputs to outputs.
// STRUCTURE
//   Package freq_meter_pkg:
//     typedef enum {IDLE, ARM, MEASURE, CLOSE, DONE} fgc_state_t
//     localparam FGC_CNT_W_DEFAULT = 32
//   Sub-module sig_sync_edge (#SYNC_STAGES): synchroniser plus rising-edge pulse.
//     Instanced for sig_in; a 2-stage plain instance is used for pll_locked.
//   Top: FSM, ref/edge/timeout counters, result registers.
// TESTING (GATE_CYCLES=100, TIMEOUT_CYCLES=300, SYNC_STAGES=2, locked=1, enable=1, ready=1)
//   1 sig_in period 10 cycles -> edge_count=10, ref_count=100, timeout=0, result_valid for 1 cycle.
//   2 sig_in period 7 cycles  -> edge_count=15, ref_count=105 (gate ends at first edge >=100).
//   3 sig_in held 0 -> 300 cycles after ARM: result_valid=1, timeout=1, counts 0; next ARM follows.
//   4 pll_locked drops 50 cycles into MEASURE -> busy=0 within 4 cycles, no result_valid.
//     After relock -> normal result as in scenario 1.
//   5 ready=0 for 500 cycles after a result -> outputs frozen, busy=0, no counting.
//     After ready=1 -> IDLE, then ARM, then the next result.
//   6 rst pulsed mid-MEASURE, between edges -> all outputs 0 asynchronously.
//     After release -> clean ARM; first result matches scenario 1.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the reciprocal frequency-measurement core.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEASURE = 3'd2,
    CLOSE   = 3'd3,
    DONE    = 3'd4
  } fgc_state_t;

  localparam int FGC_CNT_W_DEFAULT = 32;

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module sig_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[STAGES-2:0], i_async};
      r_sync_d <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_sync_d;

endmodule

// File: rtl/freq_gate_counter.sv
// Reciprocal frequency counter: counts whole sig_in periods over an edge-aligned gate
// of at least GATE_CYCLES refclk cycles and hands (edge_count, ref_count) out via valid/ready.
module freq_gate_counter
  import freq_meter_pkg::*;
#(
  parameter int          CNT_W          = FGC_CNT_W_DEFAULT,
  parameter int unsigned GATE_CYCLES    = 200000000,
  parameter int unsigned TIMEOUT_CYCLES = 400000000,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             enable,
  input  logic             sig_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] edge_count,
  output logic [CNT_W-1:0] ref_count,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LP_GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               LP_GATE_ONE  = (GATE_CYCLES == 1);

  fgc_state_t       r_state;
  logic [CNT_W-1:0] r_ref_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_result_valid;
  logic [CNT_W-1:0] r_edge_out;
  logic [CNT_W-1:0] r_ref_out;
  logic             r_timeout;

  logic             w_sig_sync_unused;
  logic             w_sig_rise;
  logic             w_locked_sync;
  logic             w_lock_rise_unused;
  logic             w_run;
  logic [CNT_W-1:0] w_ref_inc;
  logic             w_tmo_hit;

  sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sig_sync (
    .clk     (refclk),
    .rst     (rst),
    .i_async (sig_in),
    .o_sync  (w_sig_sync_unused),
    .o_rise  (w_sig_rise)
  );

  sig_sync_edge #(.STAGES(2)) u_lock_sync (
    .clk     (refclk),
    .rst     (rst),
    .i_async (pll_locked),
    .o_sync  (w_locked_sync),
    .o_rise  (w_lock_rise_unused)
  );

  assign w_run     = w_locked_sync & enable;
  assign w_ref_inc = r_ref_cnt + 1'b1;
  assign w_tmo_hit = (r_tmo_cnt == LP_TMO_LAST);

  // Abort (run low) is checked first in every busy state so it beats rise, gate end and timeout.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_ref_cnt      <= '0;
      r_edge_cnt     <= '0;
      r_tmo_cnt      <= '0;
      r_result_valid <= 1'b0;
      r_edge_out     <= '0;
      r_ref_out      <= '0;
      r_timeout      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_run) begin
            r_tmo_cnt <= '0;
            r_state   <= ARM;
          end
        end

        ARM: begin
          if (!w_run) begin
            r_state <= IDLE;
          end else if (w_sig_rise) begin
            r_ref_cnt  <= '0;
            r_edge_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_state    <= LP_GATE_ONE ? CLOSE : MEASURE;
          end else if (w_tmo_hit) begin
            r_result_valid <= 1'b1;
            r_edge_out     <= '0;
            r_ref_out      <= '0;
            r_timeout      <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        MEASURE: begin
          if (!w_run) begin
            r_state <= IDLE;
          end else if (w_sig_rise) begin
            r_ref_cnt  <= w_ref_inc;
            r_edge_cnt <= r_edge_cnt + 1'b1;
            r_tmo_cnt  <= '0;
            if (w_ref_inc == LP_GATE_LAST) r_state <= CLOSE;
          end else if (w_tmo_hit) begin
            r_result_valid <= 1'b1;
            r_edge_out     <= '0;
            r_ref_out      <= '0;
            r_timeout      <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_ref_cnt <= w_ref_inc;
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_ref_inc == LP_GATE_LAST) r_state <= CLOSE;
          end
        end

        // The first rise here terminates the gate; ref_count is its distance from the start rise.
        CLOSE: begin
          if (!w_run) begin
            r_state <= IDLE;
          end else if (w_sig_rise) begin
            r_result_valid <= 1'b1;
            r_edge_out     <= r_edge_cnt + 1'b1;
            r_ref_out      <= w_ref_inc;
            r_timeout      <= 1'b0;
            r_state        <= DONE;
          end else if (w_tmo_hit) begin
            r_result_valid <= 1'b1;
            r_edge_out     <= '0;
            r_ref_out      <= '0;
            r_timeout      <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_ref_cnt <= w_ref_inc;
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end

        DONE: begin
          if (r_result_valid && result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign result_valid = r_result_valid;
  assign edge_count   = r_edge_out;
  assign ref_count    = r_ref_out;
  assign timeout      = r_timeout;
  assign busy         = (r_state == ARM) || (r_state == MEASURE) || (r_state == CLOSE);

endmodule

// File: tb/tb_freq_gate_counter.sv
// Self-checking bench for freq_gate_counter: period table plus multi-cycle corner sequences,
// with expected results queued at stimulus time and popped on each accepted result.
module tb_freq_gate_counter;

  localparam int CW   = 32;
  localparam int GATE = 100;
  localparam int TMO  = 300;

  logic          refclk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          enable;
  logic          sig_in;
  logic          result_valid;
  logic          result_ready;
  logic [CW-1:0] edge_count;
  logic [CW-1:0] ref_count;
  logic          timeout;
  logic          busy;

  int checks      = 0;
  int errors      = 0;
  int resultsSeen = 0;
  int genPeriod   = 0;
  int genPhase    = 0;

  typedef struct {
    int   period;
    int   expEdges;
    int   expRef;
    logic expTmo;
  } vec_t;

  typedef struct {
    logic [CW-1:0] e;
    logic [CW-1:0] r;
    logic          t;
  } res_t;

  vec_t vecs[10];
  res_t expQ[$];

  freq_gate_counter #(
    .CNT_W          (CW),
    .GATE_CYCLES    (GATE),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .enable       (enable),
    .sig_in       (sig_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .edge_count   (edge_count),
    .ref_count    (ref_count),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 refclk = ~refclk;

  task automatic checkOutput(input string name, input logic [CW-1:0] act, input logic [CW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic pushExpected(input int e, input int r, input logic t);
    res_t x;
    x.e = CW'(e);
    x.r = CW'(r);
    x.t = t;
    expQ.push_back(x);
  endtask

  task automatic waitResult(input int target, input int budget);
    int n = 0;
    while (resultsSeen < target && n < budget) begin
      @(negedge refclk);
      n++;
    end
    checkOutput("result_arrived", (resultsSeen >= target) ? 1 : 0, 1);
  endtask

  task automatic quiesce();
    enable    = 1'b0;
    genPeriod = 0;
    repeat (6) @(negedge refclk);
  endtask

  task automatic waitBusy(input string name);
    int n = 0;
    while (busy !== 1'b1 && n < 50) begin
      @(negedge refclk);
      n++;
    end
    checkOutput(name, busy, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    int target;
    quiesce();
    checkOutput("idle_busy", busy, 0);
    pushExpected(v.expEdges, v.expRef, v.expTmo);
    target    = resultsSeen + 1;
    genPeriod = v.period;
    enable    = 1'b1;
    waitResult(target, 3000);
  endtask

  // Square-wave source: one rise every genPeriod cycles, held low when genPeriod < 2.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge refclk);
      if (genPeriod < 2) begin
        sig_in   = 1'b0;
        genPhase = 0;
      end else begin
        sig_in   = (genPhase < genPeriod / 2);
        genPhase = (genPhase + 1 >= genPeriod) ? 0 : genPhase + 1;
      end
    end
  end

  // Scoreboard consumer: every accepted result must match the oldest queued expectation.
  initial begin
    res_t ex;
    forever begin
      @(negedge refclk);
      #1;
      if (!rst && result_valid === 1'b1 && result_ready === 1'b1) begin
        resultsSeen++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          ex = expQ.pop_front();
          checkOutput("edge_count", edge_count, ex.e);
          checkOutput("ref_count", ref_count, ex.r);
          checkOutput("timeout", {31'd0, timeout}, {31'd0, ex.t});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=expired expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            cnt;
    int            bad;
    int            target;
    logic [CW-1:0] holdE;
    logic [CW-1:0] holdR;
    logic          holdT;

    vecs[0] = '{10,  10, 100, 1'b0};
    vecs[1] = '{7,   15, 105, 1'b0};
    vecs[2] = '{3,   34, 102, 1'b0};
    vecs[3] = '{2,   50, 100, 1'b0};
    vecs[4] = '{50,  2,  100, 1'b0};
    vecs[5] = '{33,  4,  132, 1'b0};
    vecs[6] = '{100, 1,  100, 1'b0};
    vecs[7] = '{101, 1,  101, 1'b0};
    vecs[8] = '{250, 1,  250, 1'b0};
    vecs[9] = '{0,   0,  0,   1'b1};

    rst          = 1'b1;
    pll_locked   = 1'b1;
    enable       = 1'b0;
    result_ready = 1'b1;
    repeat (3) @(negedge refclk);
    checkOutput("reset_valid", result_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_timeout", timeout, 0);
    checkOutput("reset_edge", edge_count, 0);
    checkOutput("reset_ref", ref_count, 0);
    rst = 1'b0;
    repeat (4) @(negedge refclk);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Timeout from ARM: count busy cycles up to the result, then expect an immediate re-arm.
    quiesce();
    pushExpected(0, 0, 1'b1);
    enable = 1'b1;
    waitBusy("tmo_arm_busy");
    cnt = 1;
    while (result_valid !== 1'b1 && cnt < 1000) begin
      @(negedge refclk);
      if (result_valid !== 1'b1) cnt++;
    end
    checkOutput("tmo_latency", cnt, TMO);
    @(negedge refclk);
    checkOutput("valid_one_cycle", result_valid, 0);
    @(negedge refclk);
    checkOutput("tmo_rearm_busy", busy, 1);

    // Lock loss mid-measurement aborts without a result; relock gives a normal result.
    quiesce();
    genPeriod = 10;
    enable    = 1'b1;
    waitBusy("unlock_arm_busy");
    repeat (60) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (4) @(negedge refclk);
    checkOutput("unlock_busy", busy, 0);
    bad = 0;
    repeat (30) begin
      @(negedge refclk);
      if (result_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checkOutput("unlock_quiet", bad, 0);
    pushExpected(10, 100, 1'b0);
    target     = resultsSeen + 1;
    pll_locked = 1'b1;
    waitResult(target, 3000);

    // Backpressure: a held result stays frozen and nothing counts until it is accepted.
    quiesce();
    result_ready = 1'b0;
    pushExpected(10, 100, 1'b0);
    genPeriod = 10;
    enable    = 1'b1;
    cnt = 0;
    while (result_valid !== 1'b1 && cnt < 3000) begin
      @(negedge refclk);
      cnt++;
    end
    checkOutput("bp_valid", result_valid, 1);
    holdE = edge_count;
    holdR = ref_count;
    holdT = timeout;
    bad   = 0;
    repeat (500) begin
      @(negedge refclk);
      if (result_valid !== 1'b1 || busy !== 1'b0 || edge_count !== holdE ||
          ref_count !== holdR || timeout !== holdT) bad++;
    end
    checkOutput("bp_hold", bad, 0);
    pushExpected(10, 100, 1'b0);
    target       = resultsSeen + 2;
    result_ready = 1'b1;
    waitResult(target, 3000);

    // Asynchronous reset mid-measurement clears outputs before the next clock edge.
    quiesce();
    genPeriod = 10;
    enable    = 1'b1;
    waitBusy("rst_arm_busy");
    repeat (65) @(negedge refclk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", result_valid, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_edge", edge_count, 0);
    checkOutput("async_rst_ref", ref_count, 0);
    checkOutput("async_rst_timeout", timeout, 0);
    repeat (2) @(negedge refclk);
    pushExpected(10, 100, 1'b0);
    target = resultsSeen + 1;
    rst    = 1'b0;
    waitResult(target, 3000);

    quiesce();
    checkOutput("queue_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
